// File: rtl/jtag_master_pkg.sv
// jtag_master_pkg: FSM states, TMS walk paths (LSB first) and step counts for the JTAG master
package jtag_master_pkg;
    typedef enum logic [2:0] {IDLE, TRST, SEL, SHIFT, EXIT, RESP} state_e;
    localparam logic [2:0] SEL_DR   = 3'b001;
    localparam logic [3:0] SEL_IR   = 4'b0011;
    localparam logic [5:0] TRST_SEQ = 6'b011111;
    localparam logic [1:0] EXIT_SEQ = 2'b01;
    localparam int TRST_STEPS   = 6;
    localparam int SEL_DR_STEPS = 3;
    localparam int SEL_IR_STEPS = 4;
    localparam int EXIT_STEPS   = 2;
endpackage

// File: rtl/jtag_tck_gen.sv
// jtag_tck_gen: divides clk into tck while enabled, with strobes marking the edges that raise/lower tck
module jtag_tck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tck,
    output logic rise_stb,
    output logic fall_stb
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    logic [CW-1:0] cnt;
    logic wrap;
    assign wrap     = en && cnt == CW'(CLK_DIV - 1);
    assign rise_stb = wrap && !tck;
    assign fall_stb = wrap && tck;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            tck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            tck <= 1'b0;
        end else begin
            cnt <= wrap ? '0 : cnt + CW'(1);
            tck <= tck ^ wrap;
        end
    end
endmodule

// File: rtl/jtag_master_seq.sv
// jtag_master_seq: request-driven JTAG master walking the TAP for reset, IR and DR scans
module jtag_master_seq
    import jtag_master_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int LEN_W   = $clog2(DATA_W + 1),
    parameter int CLK_DIV = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_reset_i,
    input  logic              req_ir_i,
    input  logic [LEN_W-1:0]  req_len_i,
    input  logic [DATA_W-1:0] req_data_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [DATA_W-1:0] rsp_data_o,
    output logic              busy_o,
    output logic              tck_o,
    output logic              tms_o,
    output logic              tdi_o,
    output logic              trstn_o,
    input  logic              tdo_i
);
    localparam int SW = LEN_W > 3 ? LEN_W : 3;
    state_e state, state_n;
    logic ir_q, last, tms_n, busy, rise_stb, fall_stb;
    logic [LEN_W-1:0] len_q, req_len;
    logic [DATA_W-1:0] data_q, cap, data_sh;
    logic [SW-1:0] step, step_n, nsteps;
    logic [5:0] seq, seq_sh;
    assign req_len    = req_len_i > LEN_W'(DATA_W) ? LEN_W'(DATA_W) : req_len_i;
    assign rsp_data_o = cap;
    jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (busy),
        .tck      (tck_o),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end
    // a step ends on the tck falling edge; the last step of a phase advances the FSM
    always_comb begin
        nsteps  = state == TRST  ? SW'(TRST_STEPS) :
                  state == SEL   ? SW'(ir_q ? SEL_IR_STEPS : SEL_DR_STEPS) :
                  state == SHIFT ? SW'(len_q) : SW'(EXIT_STEPS);
        last    = fall_stb && step == nsteps - SW'(1);
        step_n  = last ? '0 : step + SW'(1);
        state_n = state;
        case (state)
            IDLE:    if (req_valid_i) state_n = req_reset_i ? TRST : req_len == '0 ? RESP : SEL;
            TRST:    if (last) state_n = RESP;
            SEL:     if (last) state_n = SHIFT;
            SHIFT:   if (last) state_n = EXIT;
            EXIT:    if (last) state_n = RESP;
            RESP:    if (rsp_ready_i) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        req_ready_o = state == IDLE;
        rsp_valid_o = state == RESP;
        busy        = state != IDLE && state != RESP;
        busy_o      = busy;
    end
    // TMS/TDI for the step about to begin, looked up from the next state and step
    always_comb begin
        seq     = state_n == TRST ? TRST_SEQ :
                  state_n == SEL  ? (ir_q ? 6'(SEL_IR) : 6'(SEL_DR)) :
                  state_n == EXIT ? 6'(EXIT_SEQ) : '0;
        seq_sh  = seq >> step_n;
        tms_n   = state_n == SHIFT ? step_n == SW'(len_q) - SW'(1) : seq_sh[0];
        data_sh = data_q >> step_n;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trstn_o <= 1'b0;
            tms_o   <= 1'b1;
            tdi_o   <= 1'b0;
            ir_q    <= 1'b0;
            len_q   <= '0;
            data_q  <= '0;
            cap     <= '0;
            step    <= '0;
        end else begin
            trstn_o <= 1'b1;
            if (state == IDLE && req_valid_i) begin
                ir_q   <= req_ir_i;
                len_q  <= req_len;
                data_q <= req_data_i;
                cap    <= '0;
                step   <= '0;
                if (state_n != RESP) tms_o <= 1'b1;
            end else if (fall_stb) begin
                step  <= step_n;
                tms_o <= tms_n;
                tdi_o <= state_n == SHIFT && data_sh[0];
            end
            if (state == SHIFT && rise_stb) cap <= cap | (DATA_W'(tdo_i) << step);
        end
    end
endmodule

// File: tb/tb_jtag_master_seq.sv
// tb_jtag_master_seq: directed + randomized ops against a TAP model, loopback and expected TMS/TDO streams
module tb_jtag_master_seq;
    localparam int DW = 64;
    localparam int LW = 7;
    typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                      SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_e;
    logic clk = 0, rst_n = 0;
    logic req_valid = 0, req_reset = 0, req_ir = 0, rsp_ready = 0;
    logic [LW-1:0] req_len = '0;
    logic [DW-1:0] req_data = '0;
    logic req_ready_o, rsp_valid_o, busy_o, tck_o, tms_o, tdi_o, trstn_o, tdo;
    logic [DW-1:0] rsp_data_o;
    int tests = 0, fails = 0;
    tap_e tap = TLR;
    logic [4:0] ir_sh = '0, ir_reg = '0;
    logic [63:0] dr_sh = '0, dr_cap = '0;
    logic tap_tdo = 0, loop = 0;
    bit q_tms[$], q_tdi[$];

    always #5 clk = ~clk;
    assign tdo = loop ? tdi_o : tap_tdo;

    jtag_master_seq #(.DATA_W(DW), .CLK_DIV(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready_o),
        .req_reset_i(req_reset), .req_ir_i(req_ir), .req_len_i(req_len), .req_data_i(req_data),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data_o),
        .busy_o(busy_o), .tck_o(tck_o), .tms_o(tms_o), .tdi_o(tdi_o), .trstn_o(trstn_o), .tdo_i(tdo)
    );

    function automatic tap_e tap_next(input tap_e s, input bit t);
        case (s)
            TLR:   return t ? TLR   : RTI;
            RTI:   return t ? SELDR : RTI;
            SELDR: return t ? SELIR : CAPDR;
            CAPDR: return t ? EX1DR : SHDR;
            SHDR:  return t ? EX1DR : SHDR;
            EX1DR: return t ? UPDR  : PADR;
            PADR:  return t ? EX2DR : PADR;
            EX2DR: return t ? UPDR  : SHDR;
            UPDR:  return t ? SELDR : RTI;
            SELIR: return t ? TLR   : CAPIR;
            CAPIR: return t ? EX1IR : SHIR;
            SHIR:  return t ? EX1IR : SHIR;
            EX1IR: return t ? UPIR  : PAIR;
            PAIR:  return t ? EX2IR : PAIR;
            EX2IR: return t ? UPIR  : SHIR;
            default: return t ? SELDR : RTI;
        endcase
    endfunction

    always @(posedge tck_o or negedge trstn_o) begin
        if (!trstn_o) tap <= TLR;
        else begin
            case (tap)
                CAPIR: ir_sh <= 5'b00001;
                SHIR:  ir_sh <= {tdi_o, ir_sh[4:1]};
                UPIR:  ir_reg <= ir_sh;
                CAPDR: dr_sh <= dr_cap;
                SHDR:  dr_sh <= {tdi_o, dr_sh[63:1]};
                default: ;
            endcase
            tap <= tap_next(tap, tms_o);
        end
    end

    always @(negedge tck_o) tap_tdo <= tap == SHIR ? ir_sh[0] : tap == SHDR ? dr_sh[0] : 1'b0;

    always @(posedge tck_o) begin
        q_tms.push_back(tms_o);
        q_tdi.push_back(tdi_o);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // expected TMS stream and response derived from the op rules and the target's capture behaviour
    task automatic run_op(input bit rs, input bit ir, input int len, input logic [63:0] data,
                          input bit lp, input int dly);
        int n, cyc, sel, per, bad, lo, hi;
        bit exp_tms[$];
        logic [63:0] exp_rsp, rsp;
        n = rs ? 0 : (len > 64 ? 64 : len);
        if (rs) exp_tms = '{1, 1, 1, 1, 1, 0};
        else if (n > 0) begin
            if (ir) exp_tms = '{1, 1, 0, 0};
            else    exp_tms = '{1, 0, 0};
            for (int i = 0; i < n; i++) exp_tms.push_back(i == n - 1);
            exp_tms.push_back(1);
            exp_tms.push_back(0);
        end
        sel = ir ? 4 : 3;
        per = exp_tms.size();
        exp_rsp = '0;
        for (int i = 0; i < n; i++)
            exp_rsp[i] = lp ? data[i] : ir ? (i < 5 ? (i == 0) : data[i-5]) : dr_cap[i];
        loop = lp;
        q_tms.delete();
        q_tdi.delete();
        req_reset = rs; req_ir = ir; req_len = LW'(len); req_data = data; req_valid = 1;
        chk("req_ready_idle", req_ready_o, 1);
        @(posedge clk); #1;
        req_valid = 0;
        cyc = 0;
        while (!rsp_valid_o && cyc < 2000) begin
            @(posedge clk); #1;
            cyc++;
        end
        lo = 4 * per;
        hi = per > 0 ? lo + 2 : 0;
        chk("latency", cyc >= lo && cyc <= hi, 1);
        rsp = rsp_data_o;
        chk("rsp_data", rsp, exp_rsp);
        for (int d = 0; d < dly; d++) begin
            @(posedge clk); #1;
            chk("hold_valid", rsp_valid_o, 1);
            chk("hold_data", rsp_data_o, rsp);
            chk("hold_ready", req_ready_o, 0);
        end
        rsp_ready = 1;
        @(posedge clk); #1;
        rsp_ready = 0;
        chk("rsp_done", {rsp_valid_o, req_ready_o, busy_o}, 3'b010);
        chk("tck_rises", q_tms.size(), per);
        bad = 0;
        for (int i = 0; i < per && i < q_tms.size(); i++) if (q_tms[i] != exp_tms[i]) bad++;
        chk("tms_seq", bad, 0);
        if (n > 0) begin
            bad = 0;
            for (int i = 0; i < n; i++) if (sel + i >= q_tdi.size() || q_tdi[sel+i] != data[i]) bad++;
            chk("tdi_seq", bad, 0);
        end
        if (per > 0) begin
            chk("tap_rti", tap == RTI, 1);
            chk("tms_idle", tms_o, 0);
        end
    endtask

    initial begin
        int kind, n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_trstn", trstn_o, 0);
        chk("rst_outs", {tck_o, tms_o, tdi_o, req_ready_o, rsp_valid_o, busy_o}, 6'b010100);
        chk("rst_data", rsp_data_o, 0);
        rst_n = 1;
        #1;
        chk("trstn_hold", trstn_o, 0);
        @(posedge clk); #1;
        chk("trstn_rel", trstn_o, 1);
        chk("rel_outs", {tck_o, tms_o, req_ready_o}, 3'b011);

        run_op(1, 0, 0, 64'h0, 0, 0);
        run_op(0, 0, 32, 64'hDEADBEEF, 1, 0);
        run_op(0, 1, 5, 64'h11, 0, 0);
        chk("ir_reg", ir_reg, 5'h11);
        run_op(0, 0, 0, {$urandom, $urandom}, 0, 0);
        run_op(0, 0, 100, {$urandom, $urandom}, 1, 1);
        dr_cap = {$urandom, $urandom};
        run_op(0, 0, 64, {$urandom, $urandom}, 0, 0);
        run_op(0, 1, 7, {$urandom, $urandom}, 0, 10);

        for (int k = 0; k < 16; k++) begin
            kind = $urandom_range(0, 2);
            dr_cap = {$urandom, $urandom};
            run_op(kind == 0, kind == 1, $urandom_range(0, 70), {$urandom, $urandom},
                   1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // abort a 64-bit scan during shift step 10
        loop = 1;
        q_tms.delete();
        req_reset = 0; req_ir = 0; req_len = 7'd64; req_data = {$urandom, $urandom}; req_valid = 1;
        @(posedge clk); #1;
        req_valid = 0;
        n = 0;
        while (q_tms.size() < 14 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_reach", q_tms.size(), 14);
        @(negedge clk) rst_n = 0;
        #1;
        chk("abort_outs", {tck_o, tms_o, tdi_o, trstn_o, req_ready_o, rsp_valid_o, busy_o}, 7'b0100100);
        chk("abort_data", rsp_data_o, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        n = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (rsp_valid_o || busy_o) n++;
        end
        chk("abort_norsp", n, 0);
        run_op(1, 1, 9, {$urandom, $urandom}, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
